// File: rtl/gearbox_pkg.sv
// Shared definitions for the gearbox packer/unpacker pair.
package gearbox_pkg;

   typedef logic [7:0] byte_t;

   localparam int unsigned POPCOUNT_W = 64;

   // Callers zero-extend their lane mask to POPCOUNT_W bits.
   function automatic logic [6:0] popcount(input logic [POPCOUNT_W-1:0] v);
      logic [6:0] c;
      c = '0;
      for (int i = 0; i < POPCOUNT_W; i++) begin
         c = c + 7'(v[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry fall-through AXI-Stream buffer with a registered ready.
module axis_skid_buffer #(
   parameter int W = 8
) (
   input  logic         aclk,
   input  logic         aresetn,
   input  logic [W-1:0] s_tdata,
   input  logic         s_tvalid,
   output logic         s_tready,
   output logic [W-1:0] m_tdata,
   output logic         m_tvalid,
   input  logic         m_tready
);

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic [1:0]   count;
   logic [1:0]   count_nx;
   logic         empty;
   logic         s_fire;
   logic         m_fire;
   logic         bypass;
   logic         push;
   logic         pop;

   // An empty buffer passes the input straight through so a beat can be
   // consumed in the cycle it arrives; ready only ever looks at the count.
   assign empty    = (count == 2'd0);
   assign s_fire   = s_tvalid & s_tready;
   assign m_tvalid = !empty | s_fire;
   assign m_tdata  = empty ? s_tdata : mem[rd_ptr];
   assign m_fire   = m_tvalid & m_tready;
   assign bypass   = empty & s_fire & m_tready;
   assign push     = s_fire & !bypass;
   assign pop      = m_fire & !empty;
   assign count_nx = count + 2'(push) - 2'(pop);

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         count    <= 2'd0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         s_tready <= 1'b0;
      end else begin
         count    <= count_nx;
         s_tready <= (count_nx != 2'd2);
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
      end
   end

   always_ff @(posedge aclk) begin
      if (push) mem[wr_ptr] <= s_tdata;
   end

endmodule

// File: rtl/gearbox_unpacking.sv
// Scatters a dense byte stream into sparse output beats whose lane pattern
// comes from a separate mask stream; highest set lane carries the earliest byte.
module gearbox_unpacking
   import gearbox_pkg::*;
#(
   parameter int n  = 5,
   parameter int nb = n*8
) (
   input  logic          aclk,
   input  logic          aresetn,
   input  logic [nb-1:0] in_tdata,
   input  logic          in_tvalid,
   output logic          in_tready,
   input  logic [n-1:0]  mask_tdata,
   input  logic          mask_tvalid,
   output logic          mask_tready,
   output logic [nb-1:0] out_tdata,
   output logic [n-1:0]  out_tkeep,
   output logic          out_tvalid,
   input  logic          out_tready
);

   localparam int CW = $clog2(2*n+1);

   logic [n-1:0]    m;
   logic            mv;
   logic            emit;
   logic [CW-1:0]   k;

   logic [2*nb-1:0] buffer;
   logic [2*nb-1:0] buf_app;
   logic [2*nb-1:0] buf_nx;
   logic [CW-1:0]   byte_cnt;
   logic [CW-1:0]   cnt_app;
   logic [CW-1:0]   cnt_nx;
   logic [nb-1:0]   out_tdata_nx;
   logic [n-1:0]    out_tkeep_nx;
   logic            out_tvalid_nx;
   logic            in_tready_nx;

   axis_skid_buffer #(.W(n)) u_mask_skid (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .s_tdata  (mask_tdata),
      .s_tvalid (mask_tvalid),
      .s_tready (mask_tready),
      .m_tdata  (m),
      .m_tvalid (mv),
      .m_tready (emit)
   );

   assign k = CW'(popcount(64'(m)));

   always_comb begin
      int    j;
      byte_t lane_b;
      j             = 0;
      lane_b        = '0;
      buf_app       = buffer;
      cnt_app       = byte_cnt;
      out_tdata_nx  = out_tdata;
      out_tkeep_nx  = out_tkeep;
      out_tvalid_nx = out_tvalid;

      if (out_tvalid && out_tready) out_tvalid_nx = 1'b0;

      // Bytes below byte_cnt are always zero, so the new word can be OR-ed in
      // directly beneath the bytes already held.
      if (in_tvalid && in_tready) begin
         buf_app = buffer | ({in_tdata, {nb{1'b0}}} >> (8*int'(byte_cnt)));
         cnt_app = byte_cnt + CW'(n);
      end

      emit   = mv && !out_tvalid_nx && (cnt_app >= k);
      buf_nx = buf_app;
      cnt_nx = cnt_app;

      if (emit) begin
         out_tdata_nx = '0;
         for (int ii = n-1; ii >= 0; ii--) begin
            if (m[ii]) begin
               lane_b = buf_app[(2*n-1-j)*8 +: 8];
               out_tdata_nx[ii*8 +: 8] = lane_b;
               j++;
            end
         end
         buf_nx        = buf_app << (8*int'(k));
         cnt_nx        = cnt_app - k;
         out_tkeep_nx  = m;
         out_tvalid_nx = 1'b1;
      end

      in_tready_nx = (cnt_nx <= CW'(n));
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         buffer     <= '0;
         byte_cnt   <= '0;
         out_tdata  <= '0;
         out_tkeep  <= '0;
         out_tvalid <= 1'b0;
         in_tready  <= 1'b0;
      end else begin
         buffer     <= buf_nx;
         byte_cnt   <= cnt_nx;
         out_tdata  <= out_tdata_nx;
         out_tkeep  <= out_tkeep_nx;
         out_tvalid <= out_tvalid_nx;
         in_tready  <= in_tready_nx;
      end
   end

endmodule

// File: tb/tb_gearbox_unpacking.sv
// Directed bench for gearbox_unpacking (n=5) with a repacking reference check.
module tb_gearbox_unpacking;

   localparam int N = 5;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic [39:0]   in_tdata = '0;
   logic          in_tvalid = 1'b0;
   logic          in_tready;
   logic [4:0]    mask_tdata = '0;
   logic          mask_tvalid = 1'b0;
   logic          mask_tready;
   logic [39:0]   out_tdata;
   logic [4:0]    out_tkeep;
   logic          out_tvalid;
   logic          out_tready = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [39:0] wq[$];
   logic [4:0]  mq[$];
   logic [4:0]  sent_m[$];
   logic [7:0]  exp_b[$];
   logic [39:0] got_d[$];
   logic [4:0]  got_k[$];
   bit          saw_ready_low;

   gearbox_unpacking #(.n(N)) dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .in_tdata    (in_tdata),
      .in_tvalid   (in_tvalid),
      .in_tready   (in_tready),
      .mask_tdata  (mask_tdata),
      .mask_tvalid (mask_tvalid),
      .mask_tready (mask_tready),
      .out_tdata   (out_tdata),
      .out_tkeep   (out_tkeep),
      .out_tvalid  (out_tvalid),
      .out_tready  (out_tready)
   );

   always #5 aclk = ~aclk;

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_queues();
      wq.delete(); mq.delete(); sent_m.delete();
      exp_b.delete(); got_d.delete(); got_k.delete();
      saw_ready_low = 1'b0;
   endtask

   // mode 0: always ready, 1: ten-cycle stall, 2: random backpressure
   task automatic run_stream(input int max_cycles, input int mode, input bit need_done);
      bit          holding;
      bit          done;
      logic [39:0] hold_d;
      logic [4:0]  hold_k;
      holding = 1'b0;
      done    = 1'b0;
      hold_d  = '0;
      hold_k  = '0;
      for (int cyc = 0; cyc < max_cycles && !done; cyc++) begin
         in_tvalid   = (wq.size() > 0);
         in_tdata    = (wq.size() > 0) ? wq[0] : 40'h0;
         mask_tvalid = (mq.size() > 0);
         mask_tdata  = (mq.size() > 0) ? mq[0] : 5'h0;
         case (mode)
            0:       out_tready = 1'b1;
            1:       out_tready = !(cyc >= 3 && cyc < 13);
            default: out_tready = ($urandom_range(0, 3) != 0);
         endcase
         if (holding) begin
            check("hold_valid", out_tvalid, 1);
            check("hold_data", out_tdata, hold_d);
            check("hold_keep", out_tkeep, hold_k);
         end
         if (wq.size() > 0 && !in_tready) saw_ready_low = 1'b1;
         if (in_tvalid && in_tready) begin
            for (int b = N-1; b >= 0; b--) exp_b.push_back(wq[0][b*8 +: 8]);
            void'(wq.pop_front());
         end
         if (mask_tvalid && mask_tready) sent_m.push_back(mq.pop_front());
         if (out_tvalid && out_tready) begin
            got_d.push_back(out_tdata);
            got_k.push_back(out_tkeep);
         end
         holding = out_tvalid && !out_tready;
         hold_d  = out_tdata;
         hold_k  = out_tkeep;
         step();
         done = (wq.size() == 0) && (mq.size() == 0) && !out_tvalid &&
                (got_k.size() == sent_m.size());
      end
      in_tvalid   = 1'b0;
      mask_tvalid = 1'b0;
      if (need_done) check("stream_done", done, 1);
   endtask

   // Each beat's kept bytes, read from lane n-1 downward, must continue the
   // accepted input byte stream exactly.
   task automatic verify(input string tag);
      logic [39:0] ed;
      logic [7:0]  bv;
      check({tag, "_beats"}, got_k.size(), sent_m.size());
      for (int i = 0; i < got_k.size() && i < sent_m.size(); i++) begin
         ed = '0;
         for (int ii = N-1; ii >= 0; ii--) begin
            if (sent_m[i][ii]) begin
               bv = (exp_b.size() > 0) ? exp_b.pop_front() : 8'hxx;
               ed[ii*8 +: 8] = bv;
            end
         end
         check({tag, "_keep"}, got_k[i], sent_m[i]);
         check({tag, "_data"}, got_d[i], ed);
      end
   endtask

   initial begin
      int          total;
      logic [4:0]  rm;
      logic [39:0] w;
      saw_ready_low = 1'b0;

      // Reset state
      step(); step(); step();
      check("rst_out_tvalid", out_tvalid, 0);
      check("rst_out_tdata", out_tdata, 0);
      check("rst_out_tkeep", out_tkeep, 0);
      check("rst_in_tready", in_tready, 0);
      check("rst_mask_tready", mask_tready, 0);
      aresetn = 1'b1;
      step();
      check("rel_in_tready", in_tready, 1);
      check("rel_mask_tready", mask_tready, 1);

      // 1: full masks, back-to-back, one-cycle latency
      out_tready = 1'b1;
      in_tdata = 40'h0102030405; in_tvalid = 1'b1;
      mask_tdata = 5'h1F; mask_tvalid = 1'b1;
      step();
      check("t1_valid0", out_tvalid, 1);
      check("t1_data0", out_tdata, 40'h0102030405);
      check("t1_keep0", out_tkeep, 5'h1F);
      in_tdata = 40'h060708090A;
      step();
      check("t1_valid1", out_tvalid, 1);
      check("t1_data1", out_tdata, 40'h060708090A);
      check("t1_keep1", out_tkeep, 5'h1F);
      in_tvalid = 1'b0; mask_tvalid = 1'b0;
      step();
      check("t1_idle", out_tvalid, 0);

      // 2: sparse masks split one word
      in_tdata = 40'h0102030405; in_tvalid = 1'b1;
      mask_tdata = 5'b10100; mask_tvalid = 1'b1;
      step();
      check("t2_data0", out_tdata, 40'h0100020000);
      check("t2_keep0", out_tkeep, 5'h14);
      in_tvalid = 1'b0;
      mask_tdata = 5'b01011;
      step();
      check("t2_valid1", out_tvalid, 1);
      check("t2_data1", out_tdata, 40'h0003000405);
      check("t2_keep1", out_tkeep, 5'h0B);
      mask_tvalid = 1'b0;
      step();
      check("t2_idle", out_tvalid, 0);

      // 3: empty mask between two full masks
      in_tdata = 40'h1112131415; in_tvalid = 1'b1;
      mask_tdata = 5'h1F; mask_tvalid = 1'b1;
      step();
      check("t3_data0", out_tdata, 40'h1112131415);
      in_tdata = 40'h161718191A;
      mask_tdata = 5'h00;
      step();
      check("t3_valid1", out_tvalid, 1);
      check("t3_keep1", out_tkeep, 5'h00);
      check("t3_data1", out_tdata, 40'h0);
      in_tvalid = 1'b0;
      mask_tdata = 5'h1F;
      step();
      check("t3_data2", out_tdata, 40'h161718191A);
      check("t3_keep2", out_tkeep, 5'h1F);
      mask_tvalid = 1'b0;
      step();
      check("t3_idle", out_tvalid, 0);

      // 4: single-lane masks, continuous input
      clear_queues();
      wq.push_back(40'h2122232425);
      wq.push_back(40'h262728292A);
      wq.push_back(40'h2B2C2D2E2F);
      for (int i = 0; i < 15; i++) mq.push_back(5'b00001);
      run_stream(200, 0, 1'b1);
      check("t4_ready_low", saw_ready_low, 1);
      check("t4_first", (got_d.size() > 0) ? got_d[0] : 40'hx, 40'h21);
      check("t4_last", (got_d.size() > 14) ? got_d[14] : 40'hx, 40'h2F);
      verify("t4");

      // 5: ten-cycle output stall mid-stream
      clear_queues();
      for (int i = 0; i < 6; i++) begin
         w = {8'(8'h31 + 5*i), 8'(8'h32 + 5*i), 8'(8'h33 + 5*i), 8'(8'h34 + 5*i), 8'(8'h35 + 5*i)};
         wq.push_back(w);
         mq.push_back(5'h1F);
      end
      run_stream(200, 1, 1'b1);
      check("t5_ready_low", saw_ready_low, 1);
      verify("t5");

      // 6a: reset mid-stream
      clear_queues();
      for (int i = 0; i < 4; i++) begin
         wq.push_back(40'hA0A1A2A3A4 + 40'(i));
         mq.push_back(5'b10110);
      end
      run_stream(3, 0, 1'b0);
      out_tready = 1'b0;
      aresetn = 1'b0;
      step(); step();
      check("mid_rst_out_tvalid", out_tvalid, 0);
      check("mid_rst_out_tdata", out_tdata, 0);
      check("mid_rst_out_tkeep", out_tkeep, 0);
      check("mid_rst_in_tready", in_tready, 0);
      check("mid_rst_mask_tready", mask_tready, 0);
      aresetn = 1'b1;
      step();
      check("mid_rel_in_tready", in_tready, 1);
      check("mid_rel_mask_tready", mask_tready, 1);
      check("mid_rel_out_tvalid", out_tvalid, 0);

      // 6b: random masks and backpressure after reset
      clear_queues();
      total = 0;
      for (int i = 0; i < 30; i++) begin
         rm = 5'($urandom_range(0, 31));
         mq.push_back(rm);
         for (int b = 0; b < N; b++) total += int'(rm[b]);
      end
      for (int i = 0; i < (total + N - 1) / N; i++) begin
         w = {8'(5*i), 8'(5*i + 1), 8'(5*i + 2), 8'(5*i + 3), 8'(5*i + 4)};
         wq.push_back(w);
      end
      run_stream(2000, 2, 1'b1);
      verify("t6");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
